// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM states and the datapath width.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational access formatting: misalign detection, byte enables,
// store-lane replication and load lane extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic            misalign_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [15:0] lane;

  // Addressed byte/halfword moved down to bit 0.
  assign lane = 16'(rword_i >> {addr_i, 3'b000});

  always_comb begin
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = rword_i;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{(funct3_i == F3_B) & lane[7]}}, lane[7:0]};
      end
      F3_H, F3_HU: begin
        misalign_o = addr_i[0];
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{(funct3_i == F3_H) & lane[15]}}, lane};
      end
      F3_W: begin
        misalign_o = |addr_i;
        be_o       = 4'b1111;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: one request/ready bus transaction per aligned
// load or store, with timeout abort and registered extended load data.
module mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            DReq,
  output logic            DWe,
  output logic [XLEN-1:0] DAddr,
  output logic [3:0]      DBe,
  output logic [XLEN-1:0] DWData,
  input  logic [XLEN-1:0] DRData,
  input  logic            DReady
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             buserr_q, buserr_d;

  logic             access_c;
  logic             mis_c;
  logic             go_c;
  logic             req_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  ext_c;

  lsu_align u_align (
    .funct3_i   (funct3M),
    .addr_i     (ALUResultM[1:0]),
    .wdata_i    (WriteDataM),
    .rword_i    (DRData),
    .misalign_o (mis_c),
    .be_o       (be_c),
    .wdata_o    (DWData),
    .rdata_o    (ext_c)
  );

  assign access_c = MemReadM | MemWriteM;
  assign go_c     = access_c & ~mis_c;

  // Next state; the extended load word is captured only on the edge into DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = '0;
    buserr_d = 1'b0;
    req_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          req_c = 1'b1;
          if (DReady) begin
            state_d = ST_DONE;
            rdata_d = MemWriteM ? '0 : ext_c;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        req_c = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (DReady) begin
          state_d = ST_DONE;
          rdata_d = MemWriteM ? '0 : ext_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          state_d  = ST_DONE;
          buserr_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  // Reset masks the bus-facing strobes so an in-flight request drops at once.
  assign DReq      = req_c & ~reset;
  assign StallM    = DReq;
  assign DWe       = DReq & MemWriteM;
  assign DBe       = DReq ? be_c : 4'b0000;
  assign DAddr     = {ALUResultM[XLEN-1:2], 2'b00};
  assign MisalignM = access_c & mis_c & ~reset;
  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads/stores with varied wait states,
// misalignment, timeout, reset abort and back-to-back accesses.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        DReq, DWe;
  logic [31:0] DAddr;
  logic [3:0]  DBe;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DReady;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_base;
  int stalls;

  always #5 clk = ~clk;

  always @(posedge clk) if (DReq && DReady) hs_cnt <= hs_cnt + 1;

  mem_access #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .DReq       (DReq),
    .DWe        (DWe),
    .DAddr      (DAddr),
    .DBe        (DBe),
    .DWData     (DWData),
    .DRData     (DRData),
    .DReady     (DReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
  endtask

  // Counts stall cycles; DReady rises in stall cycle waits+1 (never if waits<0).
  // Returns inside the first non-stall cycle, or after 40 cycles.
  task automatic run_access(input int waits, output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!StallM) break;
      n++;
      DReady = (n == waits + 1);
      @(posedge clk);
      #1;
      DReady = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    DReady = 1'b0;
    DRData = 32'h0;
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    #12;
    check("rst_readdata", ReadDataM, 32'h0);
    check("rst_buserr", 32'(BusErrM), 32'h0);
    check("rst_dreq", 32'(DReq), 32'h0);
    check("rst_stall", 32'(StallM), 32'h0);
    check("rst_dbe", 32'(DBe), 32'h0);
    check("rst_dwe", 32'(DWe), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // LB 0x103, zero wait
    DRData = 32'h80FF_1234;
    set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    #1;
    check("lb_daddr", DAddr, 32'h0000_0100);
    check("lb_dbe", 32'(DBe), 32'h8);
    run_access(0, stalls);
    check("lb_stalls", 32'(stalls), 32'd1);
    check("lb_data", ReadDataM, 32'hFFFF_FF80);
    idle_cycle();
    check("lb_after_done", ReadDataM, 32'h0);

    // LBU same address
    set_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
    run_access(0, stalls);
    check("lbu_stalls", 32'(stalls), 32'd1);
    check("lbu_data", ReadDataM, 32'h0000_0080);
    idle_cycle();

    // SH 0x202 with 3 wait cycles
    DRData = 32'hFFFF_FFFF;
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
    #1;
    check("sh_dbe", 32'(DBe), 32'hC);
    check("sh_dwdata", DWData, 32'hBEEF_BEEF);
    check("sh_dwe", 32'(DWe), 32'h1);
    run_access(3, stalls);
    check("sh_stalls", 32'(stalls), 32'd4);
    check("sh_readdata", ReadDataM, 32'h0);
    check("sh_buserr", 32'(BusErrM), 32'h0);
    idle_cycle();

    // LW 0x101 misaligned
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
    #1;
    check("lw_mis_flag", 32'(MisalignM), 32'h1);
    check("lw_mis_dreq", 32'(DReq), 32'h0);
    check("lw_mis_stall", 32'(StallM), 32'h0);
    @(posedge clk);
    #1;
    check("lw_mis_stall2", 32'(StallM), 32'h0);
    check("lw_mis_readdata", ReadDataM, 32'h0);

    // SW 0x102 misaligned: no bus write
    set_op(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'hCAFE_F00D);
    #1;
    check("sw_mis_flag", 32'(MisalignM), 32'h1);
    check("sw_mis_dreq", 32'(DReq), 32'h0);
    check("sw_mis_dwe", 32'(DWe), 32'h0);
    check("sw_mis_stall", 32'(StallM), 32'h0);
    idle_cycle();

    // Illegal funct3 on an aligned address
    set_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
    #1;
    check("f3_011_mis", 32'(MisalignM), 32'h1);
    idle_cycle();

    // LH 0x300, DReady never: timeout
    DRData = 32'hDEAD_BEEF;
    set_op(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0);
    run_access(-1, stalls);
    check("to_stalls", 32'(stalls), 32'd16);
    check("to_buserr", 32'(BusErrM), 32'h1);
    check("to_readdata", ReadDataM, 32'h0);
    idle_cycle();
    check("to_buserr_clear", 32'(BusErrM), 32'h0);

    // Reset in the 2nd BUSY cycle of an LW
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rb_dreq_before", 32'(DReq), 32'h1);
    reset = 1'b1;
    #1;
    check("rb_dreq_drop", 32'(DReq), 32'h0);
    check("rb_stall_drop", 32'(StallM), 32'h0);
    check("rb_readdata", ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("rb_idle_dreq", 32'(DReq), 32'h0);
    check("rb_idle_buserr", 32'(BusErrM), 32'h0);

    // Back-to-back LW 0x400 then LHU 0x406
    hs_base = hs_cnt;
    DRData  = 32'h1122_3344;
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    run_access(0, stalls);
    check("b2b_lw_stalls", 32'(stalls), 32'd1);
    check("b2b_lw_data", ReadDataM, 32'h1122_3344);
    DRData = 32'hA5A5_8001;
    set_op(1'b1, 1'b0, 3'b101, 32'h0000_0406, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_lhu_req", 32'(DReq), 32'h1);
    run_access(0, stalls);
    check("b2b_lhu_stalls", 32'(stalls), 32'd1);
    check("b2b_lhu_data", ReadDataM, 32'h0000_A5A5);
    idle_cycle();
    idle_cycle();
    check("b2b_handshakes", 32'(hs_cnt - hs_base), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store unit of the five-stage RISC-V pipeline. It takes the address, store data and control from the EX/MEM register, runs one request/ready transaction per load or store on the data-memory bus, and sign/zero-extends load data. `ReadDataM` feeds the MEM/WB register. `StallM` freezes the front of the pipeline while a transaction is outstanding.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum BUSY cycles to wait for `DReady` before aborting with a bus error (≥2).

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemReadM`  in  1  load in the M stage.
- `MemWriteM`  in  1  store in the M stage; wins if both it and `MemReadM` are high.
- `funct3M`  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data (rs2).
- `ReadDataM`  out  32  extended load data; valid in the DONE cycle.
- `StallM`  out  1  hold IF/ID/EX/M and the EX/MEM register.
- `MisalignM`  out  1  misaligned address or illegal funct3; no bus access.
- `BusErrM`  out  1  transaction timed out; valid in the DONE cycle.
- `DReq`  out  1  bus request.
- `DWe`  out  1  bus write enable.
- `DAddr`  out  32  word address, `{ALUResultM[31:2],2'b00}`.
- `DBe`  out  4  byte enables.
- `DWData`  out  32  lane-replicated store data.
- `DRData`  in  32  read word.
- `DReady`  in  1  transaction complete; sampled on the rising edge.

## Operation
- Access = `MemReadM | MemWriteM`.
- Misaligned: H/HU with `addr[0]=1`, W with `addr[1:0]≠0`, or funct3 ∈ {011,110,111}.
  - `MisalignM=1` combinationally; no request; `StallM=0`; `ReadDataM=0`; the store is suppressed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned access: drive `DReq=1`, `StallM=1`. If `DReady=1` at the edge, capture `DRData` and go to DONE. Otherwise go to BUSY and clear the counter.
  - BUSY: `DReq=1`, `StallM=1`, counter increments each cycle.
    - On `DReady=1`: capture `DRData` and go to DONE.
    - If the counter reaches `TIMEOUT-1` with `DReady=0`: go to DONE with the error flag set.
  - DONE: `DReq=0`, `StallM=0`. `ReadDataM` is valid and `BusErrM` equals the error flag. Next state is IDLE unconditionally, so the instruction leaves M at this edge and is never reissued.
- Byte enables:
  - SB: `4'b0001<<addr[1:0]`.
  - SH: `addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `4'b1111`.
  - Loads: same masks as stores; the bus may ignore them.
- Store data: SB `{4{wd[7:0]}}`, SH `{2{wd[15:0]}}`, SW `wd`.
- Load extension: lane selected by `addr[1:0]` from the captured word, then:
  - B: sign-extend from bit 7.
  - BU: zero-extend.
  - H: sign-extend from bit 15.
  - HU: zero-extend.
  - W: pass through.
- Write, or bus error: `ReadDataM=0` in DONE.
- `DReq`, `DWe`, `DAddr`, `DBe`, `DWData` are combinational from the M inputs. Upstream holds the M inputs stable while `StallM=1`.

## Timing
- Reset values:
  - state IDLE; counter, captured word and error flag 0.
  - `ReadDataM=0`, `BusErrM=0`, `DReq=0`, `DWe=0`, `DBe=0`.
  - `StallM=0`, except that combinational outputs follow the M inputs once reset deasserts.
- Reset during BUSY: the state drops to IDLE immediately. `DReq` falls asynchronously, and the transaction is abandoned without a DONE cycle.
- Zero-wait bus (`DReady` high in the first request cycle): 1 stall cycle, then DONE. Total 2 cycles in M.
- N wait cycles: `StallM` is high for N+1 cycles, followed by 1 DONE cycle.
- Timeout: `StallM` is high for `TIMEOUT` cycles, then DONE with `BusErrM=1` for exactly 1 cycle.
- `DReady` while `DReq=0` is ignored.
- A misaligned access costs 0 stall cycles.
- Back-to-back accesses: the next instruction's request starts in the cycle after DONE.

## Structure
- Shared package `lsu_pkg`:
  - funct3 encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - FSM state typedef.
  - Word-width constant.
- Sub-module `lsu_align`: purely combinational; computes misalign detection, byte enables, store-lane replication and load extract/extend. It is instantiated once; the FSM, counter and capture register live in `mem_access`.

## Test plan
- LB at `0x103`, memory word `0x80FF_1234`, zero wait → `StallM` high 1 cycle, DONE `ReadDataM=0xFFFF_FF80`. LBU at the same address → `0x0000_0080`.
- SH at `0x202`, `WriteDataM=0x0000_BEEF`, `DReady` after 3 wait cycles → `DBe=1100`, `DWData=0xBEEF_BEEF`, `DWe=1`, `StallM` high 4 cycles.
- LW at `0x101` → `MisalignM=1`, `DReq=0`, `StallM=0`. SW at `0x102` → same response, with no write on the bus.
- LH at `0x300`, `DReady` never asserted, `TIMEOUT=16` → 16 stall cycles, then 1 cycle with `BusErrM=1` and `ReadDataM=0`.
- `reset` pulsed in the 2nd BUSY cycle of an LW → `DReq` falls in the same cycle, state IDLE, `ReadDataM=0`.
- Back-to-back LW `0x400` and LHU `0x406`, words `0x1122_3344` and `0xA5A5_8001` → `ReadDataM` `0x1122_3344`, then `0x0000_A5A5`. Exactly two requests are issued.
